// File: rtl/rca2_slice_sequencer.sv
// Drives one WIDTH-bit addition through an external 2-bit ripple-carry slice adder,
// one slice per cycle LSB first, and returns the assembled sum on a valid/ready channel.
module rca2_slice_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic             slice_cin,
    input  logic [1:0]       slice_sum,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int SLICES = WIDTH / 2;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < SLICES; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[2*i +: 2] = slice_sum;
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slice operands are only presented to the adder while a slice is in flight.
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        if (state_q == S_RUN) begin
            slice_cin = carry_q;
            for (int i = 0; i < SLICES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    slice_a = a_q[2*i +: 2];
                    slice_b = b_q[2*i +: 2];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // The final carry lives in carry_q, so out_cout holds the last result until the next accept.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

endmodule

// File: tb/tb_rca2_slice_sequencer.sv
// Directed bench: sequencer wired to a behavioural 2-bit ripple-carry slice adder, WIDTH=8.
module tb_rca2_slice_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic [1:0] slice_a;
    logic [1:0] slice_b;
    logic       slice_cin;
    logic [1:0] slice_sum;
    logic       slice_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc;
    int lat;
    logic cin_seq [0:7];

    rca2_slice_sequencer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .busy       (busy)
    );

    // External 2-bit ripple-carry slice adder.
    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 50) begin
            cin_seq[l % 8] = slice_cin;
            step();
            l++;
        end
        chk("done_timeout", 32'(out_valid), 1);
    endtask

    initial begin
        int first_acc;
        int held_bad;
        logic ovseen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_out_sum",   32'(out_sum), 0);
        chk("rst_out_cout",  32'(out_cout), 0);
        chk("rst_slice",     32'({slice_a, slice_b, slice_cin}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: carry ripples through every slice
        out_ready = 1'b1;
        accept(8'hFF, 8'h01, 1'b0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_in_ready_run", 32'(in_ready), 0);
        wait_done(lat);
        chk("t1_latency", lat, 4);
        chk("t1_sum",  32'(out_sum), 32'h00);
        chk("t1_cout", 32'(out_cout), 1);
        step();
        chk("t1_idle", 32'(in_ready), 1);

        // 2: carry pattern per slice: 2+3+1, 2+0+1, 1+3+0, 1+0+1
        accept(8'h5A, 8'h33, 1'b1);
        chk("t2_slice0_a", 32'(slice_a), 2);
        chk("t2_slice0_b", 32'(slice_b), 3);
        wait_done(lat);
        chk("t2_cin0", 32'(cin_seq[0]), 1);
        chk("t2_cin1", 32'(cin_seq[1]), 1);
        chk("t2_cin2", 32'(cin_seq[2]), 0);
        chk("t2_cin3", 32'(cin_seq[3]), 1);
        chk("t2_sum",  32'(out_sum), 32'h8E);
        chk("t2_cout", 32'(out_cout), 0);
        step();

        // 3: backpressure in DONE
        out_ready = 1'b0;
        accept(8'h12, 8'h34, 1'b0);
        wait_done(lat);
        in_valid = 1'b1;
        held_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || out_sum !== 8'h46 || out_cout !== 1'b0 || in_ready || !busy) held_bad++;
            step();
        end
        chk("t3_held", held_bad, 0);
        chk("t3_still_valid", 32'(out_valid), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t3_released", 32'(out_valid), 0);
        chk("t3_idle_ready", 32'(in_ready), 1);
        chk("t3_sum_kept", 32'(out_sum), 32'h46);
        chk("t3_rst_slice", 32'({slice_a, slice_b, slice_cin}), 0);

        // 4: back-to-back issue with out_ready held high
        accept(8'h01, 8'h02, 1'b0);
        first_acc = acc_cyc;
        wait_done(lat);
        chk("t4a_sum",  32'(out_sum), 32'h03);
        chk("t4a_cout", 32'(out_cout), 0);
        accept(8'h80, 8'h80, 1'b0);
        chk("t4_interval", acc_cyc - first_acc, 6);
        wait_done(lat);
        chk("t4b_sum",  32'(out_sum), 32'h00);
        chk("t4b_cout", 32'(out_cout), 1);
        step();

        // 5: reset in the middle of RUN
        accept(8'hAA, 8'h55, 1'b1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_in_ready", 32'(in_ready), 1);
        chk("t5_busy",     32'(busy), 0);
        chk("t5_sum_clr",  32'(out_sum), 0);
        chk("t5_cout_clr", 32'(out_cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ovseen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid || busy) ovseen = 1'b1;
            step();
        end
        chk("t5_no_result", 32'(ovseen), 0);
        accept(8'h10, 8'h20, 1'b0);
        wait_done(lat);
        chk("t5_sum",  32'(out_sum), 32'h30);
        chk("t5_cout", 32'(out_cout), 0);
        step();

        // 6: in_valid pulses outside IDLE are ignored
        out_ready = 1'b0;
        accept(8'h0F, 8'h01, 1'b0);
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_done(lat);
        chk("t6_latency", lat, 3);
        in_valid = 1'b1;
        step();
        chk("t6_done_ready", 32'(in_ready), 0);
        chk("t6_sum",  32'(out_sum), 32'h10);
        chk("t6_cout", 32'(out_cout), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_no_second", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
